// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bus bundle: redirect, icache request/response and IF/ID hand-off.
interface if_prefetch_queue_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned INST_LEN = 32,
  parameter int unsigned TRAP_LEN = 16
);
  logic                redirect_valid_i;
  logic [XLEN-1:0]     redirect_pc_i;
  logic [XLEN-1:0]     if_raddr_o;
  logic                if_raddr_valid_o;
  logic                if_raddr_ready_i;
  logic                if_rdata_valid_i;
  logic [XLEN-1:0]     if_rdata_i;
  logic                if_rerr_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [XLEN-1:0]     inst_addr_o;
  logic [INST_LEN-1:0] inst_data_o;
  logic [TRAP_LEN-1:0] trap_bus_o;
  logic                ram_stall_valid_if_o;

  // Prefetcher side
  modport master (
    input  redirect_valid_i, redirect_pc_i,
    output if_raddr_o, if_raddr_valid_o,
    input  if_raddr_ready_i, if_rdata_valid_i, if_rdata_i, if_rerr_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_addr_o, inst_data_o, trap_bus_o, ram_stall_valid_if_o
  );

  // Environment side (icache, IF/ID, redirect source)
  modport slave (
    output redirect_valid_i, redirect_pc_i,
    input  if_raddr_o, if_raddr_valid_o,
    output if_raddr_ready_i, if_rdata_valid_i, if_rdata_i, if_rerr_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_addr_o, inst_data_o, trap_bus_o, ram_stall_valid_if_o
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Sequential fetch stage: owns the fetch PC, issues one icache request at a time,
// queues returned instructions (or fetch traps) and hands them to IF/ID.
module if_prefetch_queue #(
  parameter int unsigned       XLEN       = 64,
  parameter int unsigned       INST_LEN   = 32,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [XLEN-1:0]   RESET_PC   = XLEN'(64'h8000_0000),
  parameter int unsigned       TRAP_LEN   = 16,
  parameter int unsigned       T_MISALIGN = 0,
  parameter int unsigned       T_ACCESS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  if_prefetch_queue_if.master  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [INST_LEN-1:0] INST_NOP = INST_LEN'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                halt_q, halt_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_push;
  logic [XLEN-1:0]     addr_mem [DEPTH];
  logic [INST_LEN-1:0] data_mem [DEPTH];
  logic [TRAP_LEN-1:0] trap_mem [DEPTH];

  logic                push;
  logic [INST_LEN-1:0] push_data;
  logic [TRAP_LEN-1:0] push_trap;
  logic                head_valid, pop, misaligned, has_room;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.inst_ready_i;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign has_room   = (count_q < CNT_W'(DEPTH));
  // Occupancy after this cycle's response push; decides whether to keep fetching
  assign count_push = count_q + CNT_W'(1) - CNT_W'(pop);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; redirect overrides everything
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid_i) begin
      case (state_q)
        // Outstanding response still owed unless it lands in this very cycle
        WAIT, DRAIN: state_d = bus.if_rdata_valid_i ? IDLE : DRAIN;
        // A request accepted on the redirect edge still returns a response
        REQ:         state_d = bus.if_raddr_ready_i ? DRAIN : IDLE;
        default:     state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE:  if (!halt_q && !misaligned && has_room) state_d = REQ;
        REQ:   if (bus.if_raddr_ready_i) state_d = WAIT;
        WAIT:  if (bus.if_rdata_valid_i)
                 state_d = (!bus.if_rerr_i && count_push < CNT_W'(DEPTH)) ? REQ : IDLE;
        DRAIN: if (bus.if_rdata_valid_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and datapath controls: request valid, queue push, PC/halt updates
  always_comb begin
    bus.if_raddr_valid_o = (state_q == REQ);
    push      = 1'b0;
    push_data = INST_NOP;
    push_trap = '0;
    pc_d      = pc_q;
    halt_d    = halt_q;
    if (bus.redirect_valid_i) begin
      pc_d   = bus.redirect_pc_i;
      halt_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt_q && misaligned && has_room) begin
            push                  = 1'b1;
            push_trap[T_MISALIGN] = 1'b1;
            halt_d                = 1'b1;
          end
        end
        WAIT: begin
          if (bus.if_rdata_valid_i) begin
            push = 1'b1;
            if (bus.if_rerr_i) begin
              push_trap[T_ACCESS] = 1'b1;
              halt_d              = 1'b1;
            end else begin
              push_data = pc_q[2] ? bus.if_rdata_i[XLEN-1 -: INST_LEN]
                                  : bus.if_rdata_i[INST_LEN-1:0];
              pc_d      = pc_q + XLEN'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Fetch PC and halt flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end

  // Instruction queue; redirect empties it on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_mem[PTR_W'(i)] <= '0;
        data_mem[PTR_W'(i)] <= INST_NOP;
        trap_mem[PTR_W'(i)] <= '0;
      end
    end else if (bus.redirect_valid_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr_q] <= pc_q;
        data_mem[wr_ptr_q] <= push_data;
        trap_mem[wr_ptr_q] <= push_trap;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head of queue towards IF/ID
  assign bus.if_raddr_o           = pc_q;
  assign bus.inst_valid_o         = head_valid;
  assign bus.inst_addr_o          = addr_mem[rd_ptr_q];
  assign bus.inst_data_o          = data_mem[rd_ptr_q];
  assign bus.trap_bus_o           = trap_mem[rd_ptr_q];
  assign bus.ram_stall_valid_if_o = !head_valid;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for the prefetch queue with a small behavioural icache responder.
module tb_if_prefetch_queue;

  localparam logic [63:0] NOP = 64'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_queue_if bus ();

  if_prefetch_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_resp = 0;
  int          n_pop = 0;
  logic [63:0] req_log [$];

  // icache knobs
  logic        ic_ready;
  int          ic_lat;
  logic [63:0] ic_err_addr;
  logic [63:0] ic_data;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request and check its address
  task automatic wait_req(string tag, logic [63:0] exp_addr);
    int n = 0;
    while (!bus.if_raddr_valid_o && n < 40) begin
      step();
      n++;
    end
    check({tag, "_rvalid"}, 64'(bus.if_raddr_valid_o), 64'd1);
    check({tag, "_raddr"}, bus.if_raddr_o, exp_addr);
  endtask

  // Wait (bounded) for a head entry, check it, then consume it
  task automatic expect_pop(string tag, logic [63:0] a, logic [63:0] d, logic [63:0] t);
    int n = 0;
    while (!bus.inst_valid_o && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(bus.inst_valid_o), 64'd1);
    if (bus.inst_valid_o) begin
      check({tag, "_addr"}, bus.inst_addr_o, a);
      check({tag, "_data"}, 64'(bus.inst_data_o), d);
      check({tag, "_trap"}, 64'(bus.trap_bus_o), t);
      bus.inst_ready_i = 1'b1;
      step();
      bus.inst_ready_i = 1'b0;
    end
  endtask

  // icache model: accepts on valid&ready, answers ic_lat cycles after the earliest slot
  initial begin
    logic        acc;
    logic        pend;
    logic [63:0] a;
    logic [63:0] pa;
    int          cnt;
    pend = 1'b0;
    pa   = '0;
    cnt  = 0;
    bus.if_raddr_ready_i = 1'b0;
    bus.if_rdata_valid_i = 1'b0;
    bus.if_rdata_i       = '0;
    bus.if_rerr_i        = 1'b0;
    forever begin
      @(posedge clk);
      acc = bus.if_raddr_valid_o && bus.if_raddr_ready_i;
      a   = bus.if_raddr_o;
      if (bus.if_rdata_valid_i && !bus.redirect_valid_i) n_resp++;
      if (bus.inst_valid_o && bus.inst_ready_i) n_pop++;
      if (acc) req_log.push_back(a);
      #1;
      bus.if_rdata_valid_i = 1'b0;
      bus.if_rerr_i        = 1'b0;
      if (acc) begin
        pend = 1'b1;
        pa   = a;
        cnt  = ic_lat;
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.if_rdata_valid_i = 1'b1;
          bus.if_rdata_i       = ic_data;
          bus.if_rerr_i        = (pa == ic_err_addr);
          pend                 = 1'b0;
        end else begin
          cnt--;
        end
      end
      bus.if_raddr_ready_i = ic_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sz;
    rst                  = 1'b0;
    bus.inst_ready_i     = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    ic_ready             = 1'b0;
    ic_lat               = 0;
    ic_err_addr          = '0;
    ic_data              = 64'h1111_1111_2222_2222;

    // Reset state
    #7;
    check("rst_ivalid", 64'(bus.inst_valid_o), 64'd0);
    check("rst_rvalid", 64'(bus.if_raddr_valid_o), 64'd0);
    check("rst_data", 64'(bus.inst_data_o), NOP);
    check("rst_trap", 64'(bus.trap_bus_o), 64'd0);
    check("rst_raddr", bus.if_raddr_o, 64'h8000_0000);
    check("rst_stall", 64'(bus.ram_stall_valid_if_o), 64'd1);
    @(negedge clk);
    rst      = 1'b1;
    ic_ready = 1'b1;

    // Sequential fetch with lane select by pc[2]
    expect_pop("a0", 64'h8000_0000, 64'h2222_2222, 64'd0);
    expect_pop("a1", 64'h8000_0004, 64'h1111_1111, 64'd0);
    expect_pop("a2", 64'h8000_0008, 64'h2222_2222, 64'd0);
    check("a_req0", req_log[0], 64'h8000_0000);
    check("a_req1", req_log[1], 64'h8000_0004);
    check("a_req2", req_log[2], 64'h8000_0008);

    // Back-pressure: queue fills to DEPTH, requests stop, head held
    repeat (20) step();
    check("b_queued", 64'(n_resp - n_pop), 64'd4);
    check("b_rvalid", 64'(bus.if_raddr_valid_o), 64'd0);
    check("b_head", bus.inst_addr_o, 64'h8000_000C);
    repeat (3) step();
    check("b_hold", bus.inst_addr_o, 64'h8000_000C);
    check("b_stall", 64'(bus.ram_stall_valid_if_o), 64'd0);
    ic_lat = 3;
    expect_pop("b3", 64'h8000_000C, 64'h1111_1111, 64'd0);
    wait_req("b_req", 64'h8000_001C);

    // Redirect while waiting: stale response dropped, restart at new PC
    step();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_1000;
    step();
    bus.redirect_valid_i = 1'b0;
    check("c_flush", 64'(bus.inst_valid_o), 64'd0);
    wait_req("c_req", 64'h8000_1000);
    ic_lat = 0;
    expect_pop("c0", 64'h8000_1000, 64'h2222_2222, 64'd0);

    // Misaligned redirect: trap entry, no request
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0002;
    step();
    bus.redirect_valid_i = 1'b0;
    expect_pop("d0", 64'h8000_0002, NOP, 64'h1);
    sz = req_log.size();
    repeat (10) step();
    check("d_noreq", 64'(req_log.size()), 64'(sz));
    check("d_rvalid", 64'(bus.if_raddr_valid_o), 64'd0);
    check("d_empty", 64'(bus.inst_valid_o), 64'd0);

    // Access fault at 0x80000008 halts fetching until redirect
    ic_err_addr          = 64'h8000_0008;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0000;
    step();
    bus.redirect_valid_i = 1'b0;
    expect_pop("e0", 64'h8000_0000, 64'h2222_2222, 64'd0);
    expect_pop("e1", 64'h8000_0004, 64'h1111_1111, 64'd0);
    expect_pop("e2", 64'h8000_0008, NOP, 64'h2);
    sz = req_log.size();
    repeat (10) step();
    check("e_noreq", 64'(req_log.size()), 64'(sz));
    check("e_lastreq", req_log[req_log.size() - 1], 64'h8000_0008);
    check("e_rvalid", 64'(bus.if_raddr_valid_o), 64'd0);

    // Redirect clears halt
    ic_err_addr          = '0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h8000_0010;
    step();
    bus.redirect_valid_i = 1'b0;
    expect_pop("f0", 64'h8000_0010, 64'h2222_2222, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
